// File: rtl/axi_pkg.sv
// Shared AXI encodings and the read-responder state type.
package axi_pkg;
  localparam int ID_W   = 8;
  localparam int DATA_W = 32;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  typedef enum logic [1:0] {IDLE, FETCH, SEND} rd_state_t;
endpackage

// File: rtl/axi_sram_read_slave.sv
// AXI read responder: one AR at a time, bursts streamed from a single-port sync SRAM.
// state | meaning
// IDLE  | ARREADY high, waiting for a read address
// FETCH | SRAM read issued for the current beat
// SEND  | beat presented on R, held until RREADY
module axi_sram_read_slave #(
  parameter int ID_W   = 8,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   ARID,
  input  logic [31:0]       ARADDR,
  input  logic [3:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              SRAM_CS,
  output logic [MEM_AW-1:0] SRAM_A,
  input  logic [DATA_W-1:0] SRAM_DO
);
  import axi_pkg::*;

  rd_state_t         r_state;
  rd_state_t         w_state_nxt;
  logic [ID_W-1:0]   r_id;
  logic [MEM_AW-1:0] r_addr;
  logic [3:0]        r_len;
  logic [3:0]        r_beat;
  logic              r_fixed;
  logic              w_last;
  logic              w_ar_hs;
  logic              w_r_hs;

  // Only 32-bit beats exist; size and out-of-window address bits carry no information here.
  logic w_unused;
  assign w_unused = ^{ARSIZE, ARADDR[31:MEM_AW+2], ARADDR[1:0]};

  assign w_last  = (r_beat == r_len);
  assign w_ar_hs = ARVALID && (r_state == IDLE);
  assign w_r_hs  = RREADY && (r_state == SEND);
  assign SRAM_A  = r_addr;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ARREADY     = 1'b0;
    RVALID      = 1'b0;
    RLAST       = 1'b0;
    RID         = '0;
    RDATA       = '0;
    RRESP       = RESP_OKAY;
    SRAM_CS     = 1'b0;
    case (r_state)
      IDLE: begin
        ARREADY = 1'b1;
        if (ARVALID) w_state_nxt = FETCH;
      end
      FETCH: begin
        SRAM_CS     = 1'b1;
        w_state_nxt = SEND;
      end
      SEND: begin
        // SRAM_DO stays stable while CS is low, so the beat holds under backpressure.
        RVALID = 1'b1;
        RDATA  = SRAM_DO;
        RID    = r_id;
        RLAST  = w_last;
        if (RREADY) w_state_nxt = w_last ? IDLE : FETCH;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_fixed <= 1'b0;
    end else if (w_ar_hs) begin
      r_id    <= ARID;
      r_addr  <= ARADDR[MEM_AW+1:2];
      r_len   <= ARLEN;
      r_beat  <= '0;
      r_fixed <= (ARBURST == BURST_FIXED);
    end else if (w_r_hs && !w_last) begin
      r_beat <= r_beat + 4'd1;
      if (!r_fixed) r_addr <= r_addr + MEM_AW'(1);
    end
  end
endmodule

// File: tb/tb_axi_sram_read_slave.sv
// Randomized bench for axi_sram_read_slave against an SRAM array and burst address model.
module tb_axi_sram_read_slave;
  localparam int MEM_AW = 14;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        SRAM_CS;
  logic [MEM_AW-1:0] SRAM_A;
  logic [31:0] SRAM_DO;

  logic [31:0] mem [0:(1<<MEM_AW)-1];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_hs_cyc = -100;
  bit expect_b2b = 1'b0;
  bit hold_next = 1'b0;
  logic [7:0]  nx_id;
  logic [31:0] nx_addr;
  logic [3:0]  nx_len;
  logic [1:0]  nx_burst;

  axi_sram_read_slave #(.ID_W(8), .DATA_W(32), .MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .SRAM_CS(SRAM_CS), .SRAM_A(SRAM_A), .SRAM_DO(SRAM_DO)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (SRAM_CS) SRAM_DO <= mem[SRAM_A];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Call at a negedge; returns at the negedge after the last beat (or after an abort).
  task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input int stall_beat, input int stall_n,
                           input bit rnd, input int abort_beat);
    logic [13:0] w0;
    logic [13:0] wi;
    logic [31:0] hd;
    bit          fixed;
    int          bound;
    int          st;
    int          ar_cyc;
    fixed   = (burst == 2'b00);
    w0      = addr[15:2];
    ARID    = id;
    ARADDR  = addr;
    ARLEN   = len;
    ARBURST = burst;
    ARSIZE  = 3'($urandom_range(0, 7));
    ARVALID = 1'b1;
    RREADY  = 1'b1;
    bound   = 0;
    while (!ARREADY && bound < 100) begin
      @(negedge clk);
      bound++;
    end
    chk("ar_accept", ARREADY, 1'b1);
    if (!ARREADY) begin
      ARVALID = 1'b0;
      return;
    end
    ar_cyc = cyc;
    if (expect_b2b) chk("b2b_gap", 64'(ar_cyc - last_hs_cyc), 64'd1);
    expect_b2b = 1'b0;
    @(negedge clk);
    if (hold_next) begin
      ARID = nx_id; ARADDR = nx_addr; ARLEN = nx_len; ARBURST = nx_burst; ARVALID = 1'b1;
    end else begin
      ARVALID = 1'b0;
    end
    for (int i = 0; i <= int'(len); i++) begin
      wi = fixed ? w0 : w0 + 14'(i);
      chk("fetch_cs", SRAM_CS, 1'b1);
      chk("fetch_addr", SRAM_A, wi);
      chk("fetch_arready", ARREADY, 1'b0);
      chk("fetch_rvalid", RVALID, 1'b0);
      @(negedge clk);
      chk("rvalid", RVALID, 1'b1);
      chk("rdata", RDATA, mem[wi]);
      chk("rid", RID, id);
      chk("rlast", RLAST, i == int'(len));
      chk("rresp", RRESP, 2'b00);
      chk("send_arready", ARREADY, 1'b0);
      if (i == abort_beat) begin
        RREADY = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ARVALID = 1'b0;
        chk("abort_rvalid", RVALID, 1'b0);
        chk("abort_arready", ARREADY, 1'b1);
        chk("abort_cs", SRAM_CS, 1'b0);
        RREADY = 1'b1;
        return;
      end
      if (i == stall_beat) st = stall_n;
      else if (rnd && $urandom_range(0, 2) == 0) st = int'($urandom_range(1, 3));
      else st = 0;
      hd = RDATA;
      if (st > 0) begin
        RREADY = 1'b0;
        repeat (st) begin
          @(negedge clk);
          chk("bp_rvalid", RVALID, 1'b1);
          chk("bp_rdata", RDATA, hd);
          chk("bp_rlast", RLAST, i == int'(len));
          chk("bp_cs", SRAM_CS, 1'b0);
        end
        RREADY = 1'b1;
      end
      if (i == int'(len)) last_hs_cyc = cyc;
      @(negedge clk);
    end
    chk("end_rvalid", RVALID, 1'b0);
    chk("end_arready", ARREADY, 1'b1);
  endtask

  initial begin
    for (int k = 0; k < (1 << MEM_AW); k++) mem[k] = $urandom;
    mem[4] = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) mem[64 + k] = 32'(k + 1);
    rst = 1'b1; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'b010; ARBURST = 2'b01;
    ARVALID = 1'b0; RREADY = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_arready", ARREADY, 1'b1);
    chk("rst_rvalid", RVALID, 1'b0);
    chk("rst_rlast", RLAST, 1'b0);
    chk("rst_rid", RID, 8'h00);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_cs", SRAM_CS, 1'b0);
    chk("rst_sram_a", SRAM_A, 14'h0);
    rst = 1'b0;
    @(negedge clk);

    run_burst(8'h13, 32'h0000_0010, 4'd0, 2'b01, -1, 0, 1'b0, -1);
    run_burst(8'h21, 32'h0000_0100, 4'd3, 2'b01, -1, 0, 1'b0, -1);
    run_burst(8'h22, 32'h0000_0100, 4'd3, 2'b01, 1, 3, 1'b0, -1);
    run_burst(8'h35, 32'h0000_0014, 4'd2, 2'b00, -1, 0, 1'b0, -1);
    run_burst(8'h46, 32'hABCD_FFFF, 4'd1, 2'b01, -1, 0, 1'b0, -1);

    nx_id = 8'h5A; nx_addr = 32'h0000_0200; nx_len = 4'd2; nx_burst = 2'b11;
    hold_next = 1'b1;
    run_burst(8'h57, 32'h0000_1000, 4'd15, 2'b01, -1, 0, 1'b0, -1);
    hold_next = 1'b0;
    expect_b2b = 1'b1;
    run_burst(nx_id, nx_addr, nx_len, nx_burst, -1, 0, 1'b0, -1);

    run_burst(8'h61, 32'h0000_0100, 4'd3, 2'b01, -1, 0, 1'b0, 1);
    run_burst(8'h62, 32'h0000_0040, 4'd1, 2'b01, -1, 0, 1'b0, -1);

    for (int t = 0; t < 25; t++) begin
      run_burst(8'($urandom), $urandom, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                -1, 0, 1'b1, -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/axi_sram_read_slave.md
Name: axi_sram_read_slave

Overview:
AXI read-side responder that sits behind the interconnect's slave port (S0/S1). It accepts one read-address transaction at a time and returns the burst on the R channel from a single-port synchronous SRAM. RREADY backpressure is honoured on every beat. It is the far end of the interconnect's AR/R path and pairs with that path's 8-bit extended IDs.

Parameters:
ID_W, 8, width of ARID/RID ({master idx[3:0], master ID[3:0]})
DATA_W, 32, R data width and SRAM word width
MEM_AW, 14, SRAM word-address width; byte address bits [MEM_AW+1:2] select the word

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
ARID  in  ID_W  read transaction ID
ARADDR  in  32  byte start address
ARLEN  in  4  beats minus 1
ARSIZE  in  3  beat size; only 3'b010 is supported, other values are treated as 3'b010
ARBURST  in  2  2'b00 FIXED; 2'b01 INCR; 2'b10/2'b11 treated as INCR
ARVALID  in  1  address valid
ARREADY  out  1  address ready
RID  out  ID_W  returned ID
RDATA  out  DATA_W  read data
RRESP  out  2  response; always 2'b00 OKAY
RLAST  out  1  final beat
RVALID  out  1  data valid
RREADY  in  1  master ready
SRAM_CS  out  1  SRAM chip select, active-high, read-only use
SRAM_A  out  MEM_AW  SRAM word address
SRAM_DO  in  DATA_W  SRAM read data; valid the cycle after CS and held while CS is low

Behaviour:
- Reset values: state=IDLE, ARREADY=1, RVALID=0, RLAST=0, RID=0, RDATA=0, SRAM_CS=0, SRAM_A=0.
- Reset mid-burst aborts the transaction immediately. No further R beats are issued and the next cycle is IDLE.
- FSM states: IDLE, FETCH, SEND.
- IDLE:
  - ARREADY=1; RVALID=0.
  - On ARVALID&ARREADY, latch id_q=ARID, addr_q=ARADDR[MEM_AW+1:2], len_q=ARLEN, fixed_q=(ARBURST==2'b00), and clear beat_q=0.
  - Next state is FETCH.
- FETCH:
  - ARREADY=0; SRAM_CS=1; SRAM_A=addr_q.
  - Next state is SEND unconditionally.
- SEND:
  - RVALID=1; RDATA=SRAM_DO; RID=id_q; RRESP=2'b00; RLAST=(beat_q==len_q); SRAM_CS=0.
  - No R output may change while RVALID=1 and RREADY=0.
  - On RVALID&RREADY with RLAST=1: go to IDLE.
  - On RVALID&RREADY with RLAST=0: beat_q+=1; addr_q+=1 unless fixed_q; go to FETCH.
- RID/RDATA/RLAST are don't-care when RVALID=0. They are driven 0 in IDLE and FETCH.
- Latency:
  - AR handshake at cycle T gives first RVALID at T+2.
  - An R handshake at T gives the next beat's RVALID at T+2.
  - Peak throughput is one beat per 2 cycles.
- ARREADY is a registered-state decode: high only in IDLE. No new AR is accepted until the RLAST handshake, so transactions never overlap.
- Address arithmetic: addr_q is MEM_AW bits and wraps modulo 2^MEM_AW (0x3FFF+1 -> 0x0000). ARADDR[1:0] and the bits above MEM_AW+1 are ignored; decode is the interconnect's job.
- Beat counter: beat_q is 4 bits. ARLEN=15 yields exactly 16 beats, and RLAST is asserted on the 16th beat only.
- Simultaneous events:
  - ARVALID during FETCH or SEND is not accepted and must be held by the master.
  - The final-beat handshake and a new ARVALID in the same cycle: the new AR is accepted in the following IDLE cycle, not the same cycle.

Decomposition:
- Shared package axi_pkg holds:
  - localparams ID_W/DATA_W;
  - burst encodings BURST_FIXED=2'b00, BURST_INCR=2'b01;
  - RESP_OKAY=2'b00;
  - typedef enum logic [1:0] {IDLE, FETCH, SEND} rd_state_t.
- No sub-module is needed: the FSM, counters and R output drive fit in a single module.

Test Plan:
- Single beat: ARADDR=0x0000_0010, ARLEN=0, ARID=8'h13, SRAM word 4=0xDEADBEEF, RREADY=1 -> ARREADY low from T+1, SRAM_A=4 at T+1, RVALID/RLAST=1 with RDATA=0xDEADBEEF and RID=8'h13 at T+2, ARREADY=1 at T+3.
- INCR burst: ARADDR=0x0000_0100, ARLEN=3, words 64..67=1,2,3,4 -> four beats with RDATA 1,2,3,4, RLAST only on the 4th, beats 2 cycles apart.
- Backpressure: same burst with RREADY low for 3 cycles on beat 2 -> RVALID, RDATA=2 and RLAST=0 held stable throughout, no SRAM_CS pulse, beat 3 follows 2 cycles after RREADY rises.
- FIXED and wrap:
  - ARBURST=00, ARLEN=2, addr word 5 -> SRAM_A=5 on all three fetches.
  - INCR at word 0x3FFF with ARLEN=1 -> second fetch at SRAM_A=0x0000.
- Max length plus back-to-back: ARLEN=15 -> 16 beats, RLAST on beat 16 only. A second ARVALID held during the burst is accepted exactly one cycle after the final handshake.
- Reset mid-burst: assert rst during beat 2 of ARLEN=3 -> next cycle RVALID=0, ARREADY=1, and a fresh AR completes normally.
